// File: rtl/exe_pkg.sv
// Shared definitions for the execution unit and its result collector:
// status bit positions, the status word type and the opcode encodings.
package exe_pkg;

  localparam int STAT_ERROR = 0;
  localparam int STAT_ZERO  = 1;
  localparam int STAT_NEG   = 2;
  localparam int STAT_EVEN  = 3;

  typedef logic [3:0] exe_status_t;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_CONV = 2'b11;

endpackage

// File: rtl/exe_sync_fifo.sv
// Synchronous show-ahead FIFO core: storage, pointers and occupancy count.
// The caller decides push/pop legality; the head word is read combinationally.
module exe_sync_fifo #(
  parameter int DATA_W = 36,
  parameter int DEPTH  = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [DATA_W-1:0]          i_data,
  input  logic                       i_pop,
  output logic [DATA_W-1:0]          o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  // Storage carries no reset; pointers and count alone define validity.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_rst) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/exe_result_collector.sv
// Collects execution-unit results and status into a show-ahead FIFO and keeps
// aggregate health: sticky status OR, saturating error count, sticky overflow.
module exe_result_collector
  import exe_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_wr_valid,
  input  logic [WIDTH-1:0]           i_result,
  input  logic [3:0]                 i_status,
  input  logic                       i_rd_ready,
  output logic                       o_rd_valid,
  output logic [WIDTH-1:0]           o_rd_result,
  output logic [3:0]                 o_rd_status,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_overflow,
  input  logic                       i_clr,
  output logic [3:0]                 o_sticky,
  output logic [ERR_CNT_W-1:0]       o_err_cnt
);

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v,
                                                   input logic inc);
    if (inc && (v != '1)) return v + 1'b1;
    return v;
  endfunction

  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic              w_err_inc;
  logic [WIDTH+3:0]  w_head;
  exe_status_t       r_sticky;
  logic              r_overflow;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  // A full FIFO still accepts a write when the head leaves the same cycle.
  assign w_pop     = !w_empty && i_rd_ready;
  assign w_push    = i_wr_valid && (!w_full || w_pop);
  assign w_drop    = i_wr_valid && w_full && !w_pop;
  assign w_err_inc = i_wr_valid && i_status[STAT_ERROR];

  exe_sync_fifo #(
    .DATA_W (WIDTH + 4),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_data  ({i_status, i_result}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (o_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Sticky state observes every write attempt, including dropped ones.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sticky   <= '0;
      r_overflow <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_sticky   <= (i_clr ? exe_status_t'(0) : r_sticky) | (i_wr_valid ? i_status : 4'b0000);
      r_overflow <= (i_clr ? 1'b0 : r_overflow) | w_drop;
      r_err_cnt  <= i_clr ? ERR_CNT_W'(w_err_inc) : sat_inc(r_err_cnt, w_err_inc);
    end
  end

  assign o_rd_valid  = !w_empty;
  assign o_rd_result = w_head[WIDTH-1:0];
  assign o_rd_status = w_head[WIDTH+3:WIDTH];
  assign o_full      = w_full;
  assign o_empty     = w_empty;
  assign o_overflow  = r_overflow;
  assign o_sticky    = r_sticky;
  assign o_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_exe_result_collector.sv
// Directed bench for exe_result_collector with hand-computed expectations.
module tb_exe_result_collector;

  logic        i_clk = 1'b0;
  logic        i_rst, i_wr_valid, i_rd_ready, i_clr;
  logic [31:0] i_result;
  logic [3:0]  i_status;
  logic        o_rd_valid, o_full, o_empty, o_overflow;
  logic [31:0] o_rd_result;
  logic [3:0]  o_rd_status, o_count, o_sticky;
  logic [7:0]  o_err_cnt;

  int checks = 0;
  int errors = 0;

  exe_result_collector #(.WIDTH(32), .DEPTH(8), .ERR_CNT_W(8)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_wr_valid  (i_wr_valid),
    .i_result    (i_result),
    .i_status    (i_status),
    .i_rd_ready  (i_rd_ready),
    .o_rd_valid  (o_rd_valid),
    .o_rd_result (o_rd_result),
    .o_rd_status (o_rd_status),
    .o_count     (o_count),
    .o_full      (o_full),
    .o_empty     (o_empty),
    .o_overflow  (o_overflow),
    .i_clr       (i_clr),
    .o_sticky    (o_sticky),
    .o_err_cnt   (o_err_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    i_rst = 1'b1; i_wr_valid = 1'b0; i_rd_ready = 1'b0; i_clr = 1'b0;
    i_result = '0; i_status = '0;
    tick(); tick();
    i_rst = 1'b0;
    chk("rst_count", 64'(o_count), 64'd0);
    chk("rst_empty", 64'(o_empty), 64'd1);
    chk("rst_full", 64'(o_full), 64'd0);
    chk("rst_valid", 64'(o_rd_valid), 64'd0);
    chk("rst_ovf", 64'(o_overflow), 64'd0);
    chk("rst_sticky", 64'(o_sticky), 64'd0);
    chk("rst_err", 64'(o_err_cnt), 64'd0);

    // three writes, no reads
    i_wr_valid = 1'b1;
    i_result = 32'd5;          i_status = 4'b1000; tick();
    i_result = 32'd0;          i_status = 4'b1010; tick();
    i_result = 32'h8000_0000;  i_status = 4'b0100; tick();
    i_wr_valid = 1'b0;
    chk("w3_count", 64'(o_count), 64'd3);
    chk("w3_head", 64'(o_rd_result), 64'd5);
    chk("w3_hstat", 64'(o_rd_status), 64'b1000);
    chk("w3_sticky", 64'(o_sticky), 64'b1110);
    chk("w3_err", 64'(o_err_cnt), 64'd0);

    // drain in order
    i_rd_ready = 1'b1;
    chk("dr0_head", 64'(o_rd_result), 64'd5);
    tick();
    chk("dr1_head", 64'(o_rd_result), 64'd0);
    chk("dr1_stat", 64'(o_rd_status), 64'b1010);
    tick();
    chk("dr2_head", 64'(o_rd_result), 64'h8000_0000);
    chk("dr2_stat", 64'(o_rd_status), 64'b0100);
    tick();
    i_rd_ready = 1'b0;
    chk("dr_empty", 64'(o_empty), 64'd1);
    chk("dr_valid", 64'(o_rd_valid), 64'd0);

    // fill, drop, then simultaneous write+pop while full
    i_wr_valid = 1'b1; i_status = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      i_result = 32'h100 + 32'(i);
      tick();
    end
    chk("fill_full", 64'(o_full), 64'd1);
    chk("fill_count", 64'(o_count), 64'd8);
    chk("fill_ovf0", 64'(o_overflow), 64'd0);
    i_result = 32'hDEAD; tick();
    chk("drop_ovf", 64'(o_overflow), 64'd1);
    chk("drop_count", 64'(o_count), 64'd8);
    chk("drop_head", 64'(o_rd_result), 64'h100);
    i_result = 32'h200; i_rd_ready = 1'b1; tick();
    i_wr_valid = 1'b0;
    chk("wp_count", 64'(o_count), 64'd8);
    chk("wp_head", 64'(o_rd_result), 64'h101);
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("wrap_head%0d", i), 64'(o_rd_result), 64'h100 + 64'(i));
      tick();
    end
    chk("wrap_last", 64'(o_rd_result), 64'h200);
    tick();
    i_rd_ready = 1'b0;
    chk("wrap_empty", 64'(o_empty), 64'd1);
    i_clr = 1'b1; tick(); i_clr = 1'b0;
    chk("clr_ovf", 64'(o_overflow), 64'd0);
    chk("clr_sticky", 64'(o_sticky), 64'd0);

    // error counter saturation with continuous pop
    i_wr_valid = 1'b1; i_status = 4'b0001; i_rd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      i_result = 32'(i);
      tick();
    end
    chk("sat_err", 64'(o_err_cnt), 64'd255);
    chk("sat_ovf", 64'(o_overflow), 64'd0);
    i_clr = 1'b1; i_status = 4'b1001; tick();
    i_clr = 1'b0; i_wr_valid = 1'b0;
    chk("clrw_err", 64'(o_err_cnt), 64'd1);
    chk("clrw_sticky", 64'(o_sticky), 64'b1001);
    tick(); tick();
    i_rd_ready = 1'b0;
    chk("sat_drained", 64'(o_count), 64'd0);

    // write-to-visible latency and pop-on-empty
    i_wr_valid = 1'b1; i_result = 32'h1234; i_status = 4'b1000;
    #1;
    chk("lat_n", 64'(o_rd_valid), 64'd0);
    tick();
    i_wr_valid = 1'b0;
    chk("lat_n1", 64'(o_rd_valid), 64'd1);
    chk("lat_head", 64'(o_rd_result), 64'h1234);
    i_rd_ready = 1'b1; tick();
    chk("lat_pop", 64'(o_count), 64'd0);
    tick(); tick();
    chk("empty_rdy_cnt", 64'(o_count), 64'd0);
    chk("empty_rdy_e", 64'(o_empty), 64'd1);
    i_rd_ready = 1'b0;

    // overflow across clear, then reset mid-stream
    i_wr_valid = 1'b1; i_status = 4'b0001;
    for (int i = 0; i < 9; i++) begin
      i_result = 32'h300 + 32'(i);
      tick();
    end
    chk("pre_ovf", 64'(o_overflow), 64'd1);
    i_wr_valid = 1'b0; i_clr = 1'b1; tick();
    chk("clr_only_ovf", 64'(o_overflow), 64'd0);
    i_wr_valid = 1'b1; tick();
    i_clr = 1'b0; i_wr_valid = 1'b0;
    chk("clr_drop_ovf", 64'(o_overflow), 64'd1);
    chk("clr_drop_err", 64'(o_err_cnt), 64'd1);
    chk("pre_rst_cnt", 64'(o_count), 64'd8);
    i_rst = 1'b1; i_wr_valid = 1'b1; i_result = 32'h77; tick();
    i_rst = 1'b0; i_wr_valid = 1'b0;
    chk("mrst_count", 64'(o_count), 64'd0);
    chk("mrst_ovf", 64'(o_overflow), 64'd0);
    chk("mrst_sticky", 64'(o_sticky), 64'd0);
    chk("mrst_err", 64'(o_err_cnt), 64'd0);
    tick();
    chk("mrst_after", 64'(o_rd_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
